// File: rtl/spi_transmitter.sv
// SPI transmitter: sends a 16-bit word MSB first, then 16 zero bits, framed by an active-low
// chip select, with a programmable serial clock divider and a minimum inter-frame gap.
module spi_transmitter #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        serial_clk,
  output logic        chip_select,
  output logic        mosi,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] DivLast  = 8'(CLK_DIV - 1);
  localparam logic [7:0] GapLast  = 8'(GAP_CYCLES - 1);
  localparam logic [5:0] NumEdges = 6'd32;

  typedef enum logic [2:0] {StIdle, StLead, StShift, StTrail, StGap} state_e;

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [7:0]  gap_q, gap_d;
  logic [5:0]  edge_q, edge_d;
  logic [15:0] data_q, data_d;
  logic        in_ready_q, in_ready_d;
  logic        busy_q, busy_d;
  logic        cs_q, cs_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        done_q, done_d;

  logic        div_tick;
  logic [7:0]  div_next;
  logic [3:0]  bit_idx;

  assign div_tick = (div_q == DivLast);
  assign div_next = div_tick ? 8'd0 : div_q + 8'd1;
  // After rising edge k the line presents data bit 15-k.
  assign bit_idx  = 4'(6'd15 - edge_q);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    gap_d      = gap_q;
    edge_d     = edge_q;
    data_d     = data_q;
    in_ready_d = in_ready_q;
    busy_d     = busy_q;
    cs_d       = cs_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
        cs_d       = 1'b1;
        sclk_d     = 1'b0;
        mosi_d     = 1'b0;
        // in_ready_q gates acceptance so the first cycle out of reset accepts nothing.
        if (in_valid && in_ready_q) begin
          state_d    = StLead;
          data_d     = in_data;
          mosi_d     = in_data[15];
          cs_d       = 1'b0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          div_d      = 8'd0;
          edge_d     = 6'd0;
        end
      end

      StLead: begin
        div_d = div_next;
        if (div_tick) begin
          sclk_d  = 1'b1;
          edge_d  = 6'd1;
          state_d = StShift;
        end
      end

      StShift: begin
        div_d = div_next;
        if (div_tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
            edge_d = edge_q + 6'd1;
          end else begin
            sclk_d = 1'b0;
            if (edge_q == NumEdges) begin
              state_d = StTrail;
              mosi_d  = 1'b0;
            end else begin
              mosi_d = (edge_q <= 6'd15) ? data_q[bit_idx] : 1'b0;
            end
          end
        end
      end

      StTrail: begin
        div_d = div_next;
        if (div_tick) begin
          cs_d    = 1'b1;
          done_d  = 1'b1;
          gap_d   = 8'd0;
          state_d = StGap;
        end
      end

      StGap: begin
        if (gap_q == GapLast) begin
          state_d    = StIdle;
          in_ready_d = 1'b1;
          busy_d     = 1'b0;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      div_q      <= 8'd0;
      gap_q      <= 8'd0;
      edge_q     <= 6'd0;
      data_q     <= 16'd0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      cs_q       <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      gap_q      <= gap_d;
      edge_q     <= edge_d;
      data_q     <= data_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      cs_q       <= cs_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      done_q     <= done_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign chip_select = cs_q;
  assign serial_clk  = sclk_q;
  assign mosi        = mosi_q;
  assign done        = done_q;

endmodule
